// File: rtl/dat_mem_arbiter_if.sv
// dat_mem_arbiter_if
// Bundles the core load/store request, the external loader port, the
// data-memory port and the statistics outputs of the data-memory arbiter.
//   slave  : arbiter side (takes requests and mem_dat_out, drives grants,
//            memory controls, loader read data and statistics)
//   master : environment side (core, loader and dat_mem)
// Parameters: AW address width, DW data width.
interface dat_mem_arbiter_if #(
  parameter int AW = 8,
  parameter int DW = 8
);
  // core load/store path
  logic          core_rd_en;
  logic          core_wr_en;
  logic [AW-1:0] core_addr;
  logic [DW-1:0] core_wdata;
  logic [DW-1:0] core_rdata;
  logic          core_stall;
  // loader port
  logic          ld_req;
  logic          ld_wr;
  logic          ld_lock;
  logic [AW-1:0] ld_addr;
  logic [DW-1:0] ld_wdata;
  logic          ld_gnt;
  logic          ld_rvalid;
  logic [DW-1:0] ld_rdata;
  // dat_mem port
  logic [AW-1:0] mem_addr;
  logic          mem_wr_en;
  logic          mem_rd_en;
  logic [DW-1:0] mem_dat_in;
  logic [DW-1:0] mem_dat_out;
  // statistics
  logic [15:0]   core_stall_cnt;
  logic [15:0]   ld_gnt_cnt;

  modport slave (
    input  core_rd_en, core_wr_en, core_addr, core_wdata,
    output core_rdata, core_stall,
    input  ld_req, ld_wr, ld_lock, ld_addr, ld_wdata,
    output ld_gnt, ld_rvalid, ld_rdata,
    output mem_addr, mem_wr_en, mem_rd_en, mem_dat_in,
    input  mem_dat_out,
    output core_stall_cnt, ld_gnt_cnt
  );

  modport master (
    output core_rd_en, core_wr_en, core_addr, core_wdata,
    input  core_rdata, core_stall,
    output ld_req, ld_wr, ld_lock, ld_addr, ld_wdata,
    input  ld_gnt, ld_rvalid, ld_rdata,
    input  mem_addr, mem_wr_en, mem_rd_en, mem_dat_in,
    output mem_dat_out,
    input  core_stall_cnt, ld_gnt_cnt
  );
endinterface

// File: rtl/dat_mem_arbiter.sv
// dat_mem_arbiter
// Shares the single dat_mem port between the core load/store path (default
// priority, zero added latency) and an external loader port. A wait counter
// forces a loader grant after MAX_WAIT consecutive denials; a lock lets the
// loader keep the port for up to LOCK_MAX consecutive grants.
// Ports:
//   clk   : single clock
//   reset : synchronous, active-high
//   bus   : dat_mem_arbiter_if.slave (core, loader, dat_mem, statistics)
// Optional feature: define ARB_STATS_EN to build saturating 16-bit counters
// of stalled core cycles and loader grants; otherwise both read 0.
//
// state  | meaning
// ARB    | core has priority, loader served on its own or when starved
// LOCKED | loader owns the port, core always denied
module dat_mem_arbiter #(
  parameter int AW       = 8,
  parameter int DW       = 8,
  parameter int MAX_WAIT = 4,
  parameter int LOCK_MAX = 16
) (
  input logic               clk,
  input logic               reset,
  dat_mem_arbiter_if.slave  bus
);

  typedef enum logic {ST_ARB, ST_LOCKED} state_t;

  localparam logic [3:0] WAIT_LIM   = 4'(MAX_WAIT);
  localparam logic [8:0] LOCK_LIM   = 9'(LOCK_MAX);
  // a one-grant tenure ends on the grant that would open it
  localparam bit         LOCK_MULTI = (LOCK_MAX > 1);

  state_t        state;
  logic [3:0]    wait_cnt;
  logic [7:0]    lock_cnt;
  logic [8:0]    lock_next;
  logic          core_req;
  logic          core_gnt;
  logic          ld_gnt;
  logic          ld_rd_gnt;
  logic          rvalid_q;
  logic [DW-1:0] rdata_q;
  logic [AW-1:0] addr_sel;
  logic [DW-1:0] wdata_sel;
  logic          wr_sel;
  logic          rd_sel;

  assign core_req  = bus.core_rd_en | bus.core_wr_en;
  assign lock_next = {1'b0, lock_cnt} + 9'd1;
  assign ld_rd_gnt = ld_gnt & ~bus.ld_wr;

  always_comb begin
    core_gnt = 1'b0;
    ld_gnt   = 1'b0;
    if (!reset) begin
      case (state)
        ST_ARB: begin
          if (bus.ld_req && core_req) begin
            if (wait_cnt == WAIT_LIM) ld_gnt   = 1'b1;
            else                      core_gnt = 1'b1;
          end else begin
            core_gnt = core_req;
            ld_gnt   = bus.ld_req;
          end
        end
        ST_LOCKED: ld_gnt = bus.ld_req;
        default: ;
      endcase
    end
  end

  always_comb begin
    addr_sel  = '0;
    wdata_sel = '0;
    wr_sel    = 1'b0;
    rd_sel    = 1'b0;
    if (core_gnt) begin
      // rd+wr together is a write; rd_en is forwarded unchanged
      addr_sel  = bus.core_addr;
      wdata_sel = bus.core_wdata;
      wr_sel    = bus.core_wr_en;
      rd_sel    = bus.core_rd_en;
    end else if (ld_gnt) begin
      addr_sel  = bus.ld_addr;
      wdata_sel = bus.ld_wdata;
      wr_sel    = bus.ld_wr;
      rd_sel    = ~bus.ld_wr;
    end
  end

  assign bus.mem_addr   = addr_sel;
  assign bus.mem_dat_in = wdata_sel;
  assign bus.mem_wr_en  = wr_sel;
  assign bus.mem_rd_en  = rd_sel;
  assign bus.core_rdata = bus.mem_dat_out;
  assign bus.core_stall = core_req & ~core_gnt & ~reset;
  assign bus.ld_gnt     = ld_gnt;
  assign bus.ld_rvalid  = rvalid_q;
  assign bus.ld_rdata   = rdata_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_ARB;
      wait_cnt <= '0;
      lock_cnt <= '0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      rvalid_q <= ld_rd_gnt;
      if (ld_rd_gnt) rdata_q <= bus.mem_dat_out;

      if (bus.ld_req && !ld_gnt) begin
        if (wait_cnt != WAIT_LIM) wait_cnt <= wait_cnt + 4'd1;
      end else begin
        wait_cnt <= '0;
      end

      case (state)
        ST_ARB: begin
          if (ld_gnt && bus.ld_lock && LOCK_MULTI) begin
            state    <= ST_LOCKED;
            lock_cnt <= 8'd1;
          end
        end
        ST_LOCKED: begin
          // lock_next is the tenure length including this cycle's grant
          if (!bus.ld_req || !bus.ld_lock || (lock_next >= LOCK_LIM)) begin
            state    <= ST_ARB;
            lock_cnt <= '0;
          end else begin
            lock_cnt <= lock_next[7:0];
          end
        end
        default: state <= ST_ARB;
      endcase
    end
  end

`ifdef ARB_STATS_EN
  logic [15:0] stall_cnt_q;
  logic [15:0] gnt_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
      gnt_cnt_q   <= '0;
    end else begin
      if (bus.core_stall && (stall_cnt_q != 16'hFFFF)) stall_cnt_q <= stall_cnt_q + 16'd1;
      if (ld_gnt && (gnt_cnt_q != 16'hFFFF))           gnt_cnt_q   <= gnt_cnt_q + 16'd1;
    end
  end

  assign bus.core_stall_cnt = stall_cnt_q;
  assign bus.ld_gnt_cnt     = gnt_cnt_q;
`else
  assign bus.core_stall_cnt = 16'h0000;
  assign bus.ld_gnt_cnt     = 16'h0000;
`endif

endmodule

// File: tb/tb_dat_mem_arbiter.sv
// tb_dat_mem_arbiter
// Directed scenarios (core only, loader only, starvation, lock, reset during
// lock) followed by randomized traffic, checked every cycle against a
// behavioural arbiter model and a reference copy of the memory contents.
module tb_dat_mem_arbiter;
  localparam int MAX_W = 4;
  localparam int LOCK_M = 3;

  logic clk = 1'b0;
  logic reset = 1'b1;
  bit   started = 1'b0;
  bit   mem_clear = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  dat_mem_arbiter_if #(.AW(8), .DW(8)) bus ();

  dat_mem_arbiter #(.AW(8), .DW(8), .MAX_WAIT(MAX_W), .LOCK_MAX(LOCK_M)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  // dat_mem stand-in: combinational read, write at clock edge
  logic [7:0] mem [256];
  assign bus.mem_dat_out = mem[bus.mem_addr];
  always @(posedge clk) begin
    if (mem_clear) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
    end else if (bus.mem_wr_en) begin
      mem[bus.mem_addr] <= bus.mem_dat_in;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [7:0] ref_mem [256];
  bit  owns = 1'b0;      // loader holds the port from a locked grant
  int  starve = 0;       // consecutive denied loader cycles
  int  tenure = 0;       // grants so far in the current locked tenure
  bit  exp_rvalid = 1'b0;
  logic [7:0] exp_rdata = 8'h00;
  int  stall_total = 0;
  int  gnt_total = 0;

  bit m_creq, m_gc, m_gl, m_stall;
  logic [7:0] m_addr, m_din;
  bit m_wr, m_rd;

  always @(negedge clk) begin
    if (started) begin
      m_creq = bus.core_rd_en | bus.core_wr_en;
      m_gc = 1'b0;
      m_gl = 1'b0;
      if (!reset) begin
        if (owns) begin
          m_gl = bus.ld_req;
        end else if (bus.ld_req && m_creq) begin
          m_gl = (starve == MAX_W);
          m_gc = !m_gl;
        end else begin
          m_gc = m_creq;
          m_gl = bus.ld_req;
        end
      end
      m_stall = !reset && m_creq && !m_gc;
      m_addr = 8'h00; m_din = 8'h00; m_wr = 1'b0; m_rd = 1'b0;
      if (m_gc) begin
        m_addr = bus.core_addr; m_din = bus.core_wdata;
        m_wr = bus.core_wr_en;  m_rd = bus.core_rd_en;
      end else if (m_gl) begin
        m_addr = bus.ld_addr; m_din = bus.ld_wdata;
        m_wr = bus.ld_wr;     m_rd = !bus.ld_wr;
      end

      chk("core_stall", 32'(bus.core_stall), 32'(m_stall));
      chk("ld_gnt", 32'(bus.ld_gnt), 32'(m_gl));
      chk("mem_addr", 32'(bus.mem_addr), 32'(m_addr));
      chk("mem_wr_en", 32'(bus.mem_wr_en), 32'(m_wr));
      chk("mem_rd_en", 32'(bus.mem_rd_en), 32'(m_rd));
      chk("mem_dat_in", 32'(bus.mem_dat_in), 32'(m_din));
      chk("ld_rvalid", 32'(bus.ld_rvalid), 32'(exp_rvalid));
      chk("ld_rdata", 32'(bus.ld_rdata), 32'(exp_rdata));
      if (m_gc && bus.core_rd_en && !mem_clear)
        chk("core_rdata", 32'(bus.core_rdata), 32'(ref_mem[bus.core_addr]));
`ifdef ARB_STATS_EN
      chk("core_stall_cnt", 32'(bus.core_stall_cnt), 32'(stall_total));
      chk("ld_gnt_cnt", 32'(bus.ld_gnt_cnt), 32'(gnt_total));
`else
      chk("core_stall_cnt", 32'(bus.core_stall_cnt), 32'd0);
      chk("ld_gnt_cnt", 32'(bus.ld_gnt_cnt), 32'd0);
`endif

      // state after the coming clock edge
      if (mem_clear) for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
      if (reset) begin
        owns = 1'b0; starve = 0; tenure = 0;
        exp_rvalid = 1'b0; exp_rdata = 8'h00;
        stall_total = 0; gnt_total = 0;
      end else begin
        exp_rvalid = m_gl && !bus.ld_wr;
        if (exp_rvalid) exp_rdata = ref_mem[bus.ld_addr];
        if (!mem_clear) begin
          if (m_gc && bus.core_wr_en) ref_mem[bus.core_addr] = bus.core_wdata;
          if (m_gl && bus.ld_wr)      ref_mem[bus.ld_addr]   = bus.ld_wdata;
        end
        if (bus.ld_req && !m_gl) starve = (starve < MAX_W) ? starve + 1 : MAX_W;
        else                     starve = 0;
        if (owns) begin
          if (m_gl) tenure++;
          if (!bus.ld_req || !bus.ld_lock || tenure >= LOCK_M) owns = 1'b0;
        end else if (m_gl && bus.ld_lock && LOCK_M > 1) begin
          owns = 1'b1;
          tenure = 1;
        end
        if (m_stall && stall_total < 65535) stall_total++;
        if (m_gl && gnt_total < 65535)      gnt_total++;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.core_rd_en = 1'b0; bus.core_wr_en = 1'b0;
    bus.core_addr = 8'h00; bus.core_wdata = 8'h00;
    bus.ld_req = 1'b0; bus.ld_wr = 1'b0; bus.ld_lock = 1'b0;
    bus.ld_addr = 8'h00; bus.ld_wdata = 8'h00;
  endtask

  initial begin
    idle();
    step();
    started = 1'b1;
    step();
    step();
    reset = 1'b0;
    mem_clear = 1'b0;

    // core only: store then load
    bus.core_wr_en = 1'b1; bus.core_addr = 8'h10; bus.core_wdata = 8'h5A;
    #3;
    chk("core_only_wr_stall", 32'(bus.core_stall), 32'd0);
    chk("core_only_wr_ldgnt", 32'(bus.ld_gnt), 32'd0);
    step();
    bus.core_wr_en = 1'b0; bus.core_rd_en = 1'b1;
    #3;
    chk("core_only_rd_stall", 32'(bus.core_stall), 32'd0);
    chk("core_only_rdata", 32'(bus.core_rdata), 32'h5A);
    step();
    idle();

    // loader only: write then read
    bus.ld_req = 1'b1; bus.ld_wr = 1'b1; bus.ld_addr = 8'h20; bus.ld_wdata = 8'hC3;
    #3;
    chk("ld_only_wr_gnt", 32'(bus.ld_gnt), 32'd1);
    step();
    bus.ld_wr = 1'b0;
    #3;
    chk("ld_only_rd_gnt", 32'(bus.ld_gnt), 32'd1);
    step();
    bus.ld_req = 1'b0;
    #3;
    chk("ld_only_rvalid", 32'(bus.ld_rvalid), 32'd1);
    chk("ld_only_rdata", 32'(bus.ld_rdata), 32'hC3);

    // starvation from a clean reset
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    bus.core_rd_en = 1'b1; bus.core_addr = 8'h10;
    bus.ld_req = 1'b1; bus.ld_wr = 1'b0; bus.ld_addr = 8'h20;
    for (int i = 1; i <= 5; i++) begin
      #3;
      chk("starve_ld_gnt", 32'(bus.ld_gnt), 32'(i == 5));
      chk("starve_core_stall", 32'(bus.core_stall), 32'(i == 5));
      step();
      if (i == 5) bus.ld_req = 1'b0;
    end
    #3;
    chk("starve_after_stall", 32'(bus.core_stall), 32'd0);
`ifdef ARB_STATS_EN
    chk("stats_stall_cnt", 32'(bus.core_stall_cnt), 32'd1);
    chk("stats_gnt_cnt", 32'(bus.ld_gnt_cnt), 32'd1);
`else
    chk("stats_stall_cnt", 32'(bus.core_stall_cnt), 32'd0);
    chk("stats_gnt_cnt", 32'(bus.ld_gnt_cnt), 32'd0);
`endif

    // lock: 4 starved cycles, then a 3-grant tenure, then the core again
    step();
    bus.ld_req = 1'b1; bus.ld_lock = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      #3;
      chk("lock_ld_gnt", 32'(bus.ld_gnt), 32'(i >= 5 && i <= 7));
      chk("lock_core_stall", 32'(bus.core_stall), 32'(i >= 5 && i <= 7));
      step();
    end

    // reset in the middle of a locked tenure
    bus.core_rd_en = 1'b0;
    #3;
    chk("rst_lock_enter_gnt", 32'(bus.ld_gnt), 32'd1);
    step();
    reset = 1'b1; bus.core_rd_en = 1'b1;
    #3;
    chk("rst_forced_gnt", 32'(bus.ld_gnt), 32'd0);
    chk("rst_forced_stall", 32'(bus.core_stall), 32'd0);
    chk("rst_forced_rd_en", 32'(bus.mem_rd_en), 32'd0);
    step();
    reset = 1'b0;
    #3;
    chk("rst_core_gnt_stall", 32'(bus.core_stall), 32'd0);
    chk("rst_ld_gnt", 32'(bus.ld_gnt), 32'd0);
    chk("rst_rvalid", 32'(bus.ld_rvalid), 32'd0);
    step();
    idle();

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      step();
      reset = ($urandom_range(0, 99) == 0);
      bus.core_rd_en = ($urandom_range(0, 99) < 45);
      bus.core_wr_en = ($urandom_range(0, 99) < 25);
      bus.core_addr  = 8'($urandom_range(0, 15));
      bus.core_wdata = 8'($urandom);
      bus.ld_req     = ($urandom_range(0, 99) < 60);
      bus.ld_wr      = ($urandom_range(0, 99) < 40);
      bus.ld_lock    = ($urandom_range(0, 99) < 50);
      bus.ld_addr    = 8'($urandom_range(0, 15));
      bus.ld_wdata   = 8'($urandom);
    end
    step();
    idle();
    step();
    step();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/dat_mem_arbiter.md
# dat_mem_arbiter

Arbitrates the single data-memory port (`dat_mem`) between the core's load/store path and an external loader port used to preload or dump memory while the program runs. The core has default priority. A wait counter guarantees the loader is served within a bounded number of cycles, and a lock lets the loader hold the port for back-to-back bursts. The block sits between the core (address/data from `alu`/`reg_file`, stall to `PC`) and `dat_mem`.

## Interface
Parameters:
- `AW`, 8, address width.
- `DW`, 8, data width.
- `MAX_WAIT`, 4, consecutive denied loader cycles before the loader is forced a grant (range 1–15).
- `LOCK_MAX`, 16, maximum consecutive cycles of a locked loader tenure (range 1–255).

Ports:
- `clk`, input, 1, the single clock.
- `reset`, input, 1, synchronous, active-high.
- `core_rd_en`, input, 1, core load request (`MemtoReg`).
- `core_wr_en`, input, 1, core store request (`MemWrite`).
- `core_addr`, input, AW, core address (ALU result).
- `core_wdata`, input, DW, core store data.
- `core_rdata`, output, DW, load data; combinational pass-through of `mem_dat_out`.
- `core_stall`, output, 1, core request denied this cycle; PC must hold and the register file must not write.
- `ld_req`, input, 1, loader request.
- `ld_wr`, input, 1, 1 = write, 0 = read.
- `ld_lock`, input, 1, request to keep ownership after this grant.
- `ld_addr`, input, AW, loader address.
- `ld_wdata`, input, DW, loader write data.
- `ld_gnt`, output, 1, loader access performed this cycle.
- `ld_rvalid`, output, 1, registered; pulses one cycle after a granted loader read.
- `ld_rdata`, output, DW, registered read data; valid with `ld_rvalid`.
- `mem_addr`, output, AW, to `dat_mem.addr`.
- `mem_wr_en`, output, 1, to `dat_mem.wr_en`.
- `mem_rd_en`, output, 1, to `dat_mem.rd_en`.
- `mem_dat_in`, output, DW, to `dat_mem.dat_in`.
- `mem_dat_out`, input, DW, from `dat_mem.dat_out`.
- `core_stall_cnt`, output, 16, statistics (see Configuration).
- `ld_gnt_cnt`, output, 16, statistics (see Configuration).

## Operation
- `core_req = core_rd_en | core_wr_en`. If both enables are high, the access is treated as a write (`rd_en` is still forwarded).
- FSM states:
  - ARB: arbitrating each cycle.
  - LOCKED: loader owns the port.
- Grant in ARB:
  - Only one requester: that requester is granted.
  - Both request: core is granted unless `wait_cnt == MAX_WAIT`, in which case the loader is granted.
- Grant in LOCKED: loader is granted if `ld_req`; the core is always denied.
- Transitions:
  - ARB→LOCKED when the loader is granted with `ld_lock=1`; `lock_cnt` loads 1.
  - LOCKED→ARB when `ld_lock=0`, when `ld_req=0`, or when `lock_cnt == LOCK_MAX` (checked after the current grant).
  - `lock_cnt` increments on each locked grant.
- `wait_cnt`:
  - Increments, saturating at `MAX_WAIT`, when `ld_req & ~ld_gnt`.
  - Clears when `ld_gnt=1` or `ld_req=0`.
- Memory mux:
  - Granted requester drives `mem_addr`, `mem_wr_en`, `mem_rd_en`, `mem_dat_in`.
  - No grant: all enables 0, address and data 0.
- `core_stall = core_req & ~core_gnt`, combinational.
- An idle loader never stalls the core.
- Widths: all counters saturate and never wrap.

## Timing
- Grant, stall and memory controls are combinational from the current requests and registered state; there is zero added latency for core accesses.
- Core loads: data is available the same cycle as the grant, matching the combinational read of `dat_mem`.
- Loader reads: `ld_rvalid` and `ld_rdata` appear exactly 1 cycle after `ld_gnt`. A new loader read may be granted every cycle.
- Writes commit at the clock edge ending the grant cycle.
- Reset (synchronous, applied for any duration, including mid-lock):
  - State returns to ARB.
  - `wait_cnt`, `lock_cnt`, `ld_rvalid`, `ld_rdata`, and both statistics counters are cleared to 0.
  - While `reset=1`, all grants, `core_stall`, and the memory enables are forced to 0.
- Simultaneous `ld_req` falling edge and lock expiry: the FSM returns to ARB with `wait_cnt` at 0.

## Configuration
- `ARB_STATS_EN` defined:
  - `core_stall_cnt` counts cycles with `core_stall=1`.
  - `ld_gnt_cnt` counts cycles with `ld_gnt=1`.
  - Both saturate at 16'hFFFF and clear on reset.
- `ARB_STATS_EN` undefined: both ports are tied to 0 and no counter flops are built.

## Test plan
- Core only:
  - Stimulus: store 8'h5A to 8'h10, then load from 8'h10.
  - Required: `core_stall=0` throughout, `core_rdata=8'h5A`, `ld_gnt=0`.
- Loader only:
  - Stimulus: loader write 8'hC3 to 8'h20, then read 8'h20.
  - Required: `ld_gnt=1` both cycles; `ld_rvalid=1` and `ld_rdata=8'hC3` in the cycle after the read.
- Starvation (`MAX_WAIT=4`):
  - Stimulus: core loads every cycle while `ld_req` is held high.
  - Required: the loader is denied 4 cycles, then granted on the 5th with `core_stall=1` that cycle; `wait_cnt` returns to 0.
- Lock:
  - Stimulus: `LOCK_MAX=3`; loader holds `ld_req=ld_lock=1` while the core also requests.
  - Required: loader granted 3 consecutive cycles, core stalled 3 cycles, then the core is granted on cycle 4.
- Reset mid-lock:
  - Stimulus: assert `reset` for 1 cycle during LOCKED.
  - Required: next cycle is in ARB, `ld_rvalid=0`, and a pending core request is granted.
- Statistics (with `ARB_STATS_EN`):
  - Stimulus: run the starvation scenario.
  - Required: `core_stall_cnt=1`, `ld_gnt_cnt=1`; without the macro, both read 0.
